layer_linebuf: RTL and testbench

LAYER_LINEBUF -- requirements
Module: layer_linebuf

---
 rtl/layer_linebuf.sv | 119 +++++++++++
 tb/tb_layer_linebuf.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/layer_linebuf.sv
// ----------------------------------------------------------------------------
// layer_linebuf
//
// Double-buffered line memory placed between a layer renderer and the
// composer. The renderer fills the back bank (~front_bank) while the composer
// reads the front bank. A start_of_line pulse swaps the roles of the two banks.
//
// Ports
//   clk             rising-edge clock for all logic
//   rst             synchronous active-low reset
//   start_of_line   one-cycle pulse, toggles front_bank
//   linebuf_wridx   renderer write index (back bank)
//   linebuf_wrdata  renderer write data
//   linebuf_wren    renderer write enable
//   rd_idx          composer read index (front bank)
//   rd_en           composer read enable
//   rd_data         registered read data, held while rd_en is low
//   rd_valid        high one cycle after an accepted rd_en
//   front_bank      bank currently readable by the composer
//
// Configuration macro
//   LINEBUF_CLEAR_ON_READ_EN  when defined, every accepted read also writes 0
//                             to the word it returns, so a bank is blank
//                             (transparent) once it becomes the back bank.
//
// Bank contents are never reset.
// ----------------------------------------------------------------------------
module layer_linebuf #(
    parameter int IDX_W  = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_of_line,
    input  logic [IDX_W-1:0]  linebuf_wridx,
    input  logic [DATA_W-1:0] linebuf_wrdata,
    input  logic              linebuf_wren,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              front_bank
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [DATA_W-1:0] r_bank0 [DEPTH];
    logic [DATA_W-1:0] r_bank1 [DEPTH];
    logic              r_front;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    logic              w_wr_bank0;
    logic              w_wr_bank1;
    logic              w_clr_bank0;
    logic              w_clr_bank1;
    logic [DATA_W-1:0] w_front_word;

    // All bank selects use the pre-toggle r_front, so a write or read that
    // coincides with start_of_line still targets the bank roles of this line.
    always_comb begin
        w_wr_bank0  = linebuf_wren &&  r_front;
        w_wr_bank1  = linebuf_wren && !r_front;
`ifdef LINEBUF_CLEAR_ON_READ_EN
        w_clr_bank0 = rd_en && !r_front;
        w_clr_bank1 = rd_en &&  r_front;
`else
        w_clr_bank0 = 1'b0;
        w_clr_bank1 = 1'b0;
`endif
        w_front_word = r_front ? r_bank1[rd_idx] : r_bank0[rd_idx];
    end

    // Renderer write and read-clear never hit the same bank in one cycle:
    // one targets the back bank, the other the front bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (w_wr_bank0) begin
                r_bank0[linebuf_wridx] <= linebuf_wrdata;
            end
            if (w_clr_bank0) begin
                r_bank0[rd_idx] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (w_wr_bank1) begin
                r_bank1[linebuf_wridx] <= linebuf_wrdata;
            end
            if (w_clr_bank1) begin
                r_bank1[rd_idx] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_front    <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (start_of_line) begin
                r_front <= ~r_front;
            end
            // Read returns the word as it was before any same-edge clear.
            if (rd_en) begin
                r_rd_data <= w_front_word;
            end
            r_rd_valid <= rd_en;
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;
    assign front_bank = r_front;

endmodule

// File: tb/tb_layer_linebuf.sv
// ----------------------------------------------------------------------------
// tb_layer_linebuf
//
// Directed and randomized stimulus for layer_linebuf with default parameters.
// Expected values come from a reference model holding the two banks as plain
// arrays plus a per-entry "has been written" flag; read data of never-written
// entries is not compared. Compile with +define+LINEBUF_CLEAR_ON_READ_EN to
// exercise the read-clear build against the matching model behaviour.
// ----------------------------------------------------------------------------
module tb_layer_linebuf;

    localparam int IDX_W  = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << IDX_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_of_line;
    logic [IDX_W-1:0]  linebuf_wridx;
    logic [DATA_W-1:0] linebuf_wrdata;
    logic              linebuf_wren;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              front_bank;

    layer_linebuf #(
        .IDX_W (IDX_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_of_line (start_of_line),
        .linebuf_wridx (linebuf_wridx),
        .linebuf_wrdata(linebuf_wrdata),
        .linebuf_wren  (linebuf_wren),
        .rd_idx        (rd_idx),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .front_bank    (front_bank)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [DATA_W-1:0] m_mem   [2][DEPTH];
    bit                m_known [2][DEPTH];
    int                m_front;
    logic [DATA_W-1:0] m_data;
    bit                m_data_known;
    logic              m_valid;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance the model by the same edge, then
    // compare outputs 1 time unit after the edge.
    task automatic step(input logic rstn, input logic sol,
                        input logic we, input int widx, input int wd,
                        input logic re, input int ridx);
        int wi;
        int ri;
        wi = widx % DEPTH;
        ri = ridx % DEPTH;
        rst            = rstn;
        start_of_line  = sol;
        linebuf_wren   = we;
        linebuf_wridx  = IDX_W'(wi);
        linebuf_wrdata = DATA_W'(wd);
        rd_en          = re;
        rd_idx         = IDX_W'(ri);
        @(posedge clk);
        if (!rstn) begin
            m_front      = 0;
            m_data       = '0;
            m_data_known = 1'b1;
            m_valid      = 1'b0;
        end else begin
            if (re) begin
                m_data       = m_mem[m_front][ri];
                m_data_known = m_known[m_front][ri];
`ifdef LINEBUF_CLEAR_ON_READ_EN
                m_mem[m_front][ri]   = '0;
                m_known[m_front][ri] = 1'b1;
`endif
            end
            m_valid = re;
            if (we) begin
                m_mem[1 - m_front][wi]   = DATA_W'(wd);
                m_known[1 - m_front][wi] = 1'b1;
            end
            if (sol) m_front = 1 - m_front;
        end
        #1;
        chk("front_bank", 32'(front_bank), 32'(m_front));
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        if (m_data_known) chk("rd_data", 32'(rd_data), 32'(m_data));
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[b][i]   = '0;
                m_known[b][i] = 1'b0;
            end
        m_front = 0; m_data = '0; m_data_known = 1'b0; m_valid = 1'b0;

        // Reset state.
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
        chk("reset_front", 32'(front_bank), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);

        // Write 5 = 0x3C, swap, read 5.
        step(1'b1, 1'b0, 1'b1, 5, 'h3C, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 5);
        chk("basic_rd_data", 32'(rd_data), 32'h3C);
        chk("basic_rd_valid", 32'(rd_valid), 32'd1);
        idle();
        chk("basic_valid_drop", 32'(rd_valid), 32'd0);
        chk("basic_data_hold", 32'(rd_data), 32'h3C);

        // Write 7 = 0xAA together with start_of_line: lands in the pre-toggle
        // back bank, which is readable again after two more swaps.
        step(1'b1, 1'b1, 1'b1, 7, 'hAA, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 7);
        chk("sol_write_rd_data", 32'(rd_data), 32'hAA);

        // Read 10 twice across a bank round trip.
        step(1'b1, 1'b0, 1'b1, 10, 'h55, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 10);
        chk("clr_first_read", 32'(rd_data), 32'h55);
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 10);
`ifdef LINEBUF_CLEAR_ON_READ_EN
        chk("clr_second_read", 32'(rd_data), 32'h00);
`else
        chk("clr_second_read", 32'(rd_data), 32'h55);
`endif

        // Index extremes.
        step(1'b1, 1'b0, 1'b1, 1023, 'h11, 1'b0, 0);
        step(1'b1, 1'b0, 1'b1, 0, 'h22, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1023);
        chk("idx_max", 32'(rd_data), 32'h11);
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 0);
        chk("idx_zero", 32'(rd_data), 32'h22);

        // Reset mid-line with a read pending and rd_en still high.
        step(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1023);
        step(1'b0, 1'b0, 1'b1, 3, 'h77, 1'b1, 0);
        chk("midreset_front", 32'(front_bank), 32'd0);
        chk("midreset_rd_data", 32'(rd_data), 32'd0);
        chk("midreset_rd_valid", 32'(rd_valid), 32'd0);

        // Three consecutive start_of_line pulses from front_bank = 0.
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        chk("sol_seq_1", 32'(front_bank), 32'd1);
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        chk("sol_seq_2", 32'(front_bank), 32'd0);
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0);
        chk("sol_seq_3", 32'(front_bank), 32'd1);

        // Randomized traffic on a small index window plus the top index so
        // reads frequently hit written entries; occasional resets.
        for (int n = 0; n < 600; n++) begin
            int  sel;
            logic rr;
            sel = int'($urandom_range(0, 15));
            rr  = ($urandom_range(0, 49) != 0);
            step(rr,
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) != 0),
                 (sel == 15) ? 1023 : int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 255)),
                 ($urandom_range(0, 1) == 1),
                 (sel == 14) ? 1023 : int'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
